// File: rtl/tagged_ram.sv
// Main-memory responder for the CPU's multiplexed tagged bus: 64-bit data plus 8-bit tag per word,
// address latched on strobe, optional zero-fill sweep after reset.
module tagged_ram #(
  parameter int AW    = 20,
  parameter bit CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_busy,
  output logic        o_err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] ptr;
  logic          addr_valid;
  logic [71:0]   mem [DEPTH];

  logic          in_init;
  logic          any_strb;
  logic          multi_strb;
  logic          err_next;
  logic          we;
  logic          rd_en;
  logic [AW-1:0] waddr;
  logic [71:0]   wdata;
  logic [71:0]   rdata;

  assign in_init    = (state == ST_INIT);
  assign any_strb   = i_astb | i_wr | i_rd;
  assign multi_strb = (i_astb & i_wr) | (i_astb & i_rd) | (i_wr & i_rd);
  assign err_next   = (in_init & any_strb) | multi_strb | ((i_rd | i_wr) & ~addr_valid);

  // The sweep and the bus share one write port; bus commands are dropped during INIT.
  assign we    = ~reset & (in_init | (~i_astb & i_wr & addr_valid));
  assign waddr = in_init ? ptr : addr;
  assign wdata = in_init ? 72'd0 : {i_tag, i_ad};
  assign rd_en = ~in_init & ~i_astb & ~i_wr & i_rd & addr_valid;
  assign rdata = mem[addr];

  assign o_busy = in_init;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR ? ST_INIT : ST_READY;
      addr       <= '0;
      addr_valid <= 1'b0;
      ptr        <= '0;
      o_data     <= '0;
      o_tag      <= '0;
      o_err      <= 1'b0;
    end else begin
      o_err <= err_next;
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (&ptr) state <= ST_READY;
        end
        default: begin
          if (i_astb) begin
            addr       <= i_ad[AW-1:0];
            addr_valid <= 1'b1;
          end else if (rd_en) begin
            o_data <= rdata[63:0];
            o_tag  <= rdata[71:64];
          end
        end
      endcase
    end
  end

endmodule
